// File: rtl/instr_write_sequencer.sv
// instr_write_sequencer: buffers a valid/ready instruction stream in a small FIFO
// and issues ordered register writes to instr_register, tracking written addresses.
// Ports: clk, reset_n (sync, active low); start/mode run control;
//   in_valid/in_ready/in_opcode/in_operand_a/in_operand_b producer stream;
//   load_en/write_pointer/opcode/operand_a/operand_b register write port;
//   written_mask/write_count/busy/done run status.

package instr_pkg;
    typedef logic [2:0]         opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  op;
        operand_t a;
        operand_t b;
    } instr_t;
endpackage

module instr_write_sequencer
    import instr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WRITES = 20,
    parameter logic [4:0]  SEED       = 5'h1F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  opcode_t     in_opcode,
    input  operand_t    in_operand_a,
    input  operand_t    in_operand_b,
    output logic        load_en,
    output address_t    write_pointer,
    output opcode_t     opcode,
    output operand_t    operand_a,
    output operand_t    operand_b,
    output logic [31:0] written_mask,
    output logic [7:0]  write_count,
    output logic        busy,
    output logic        done
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  MAXW     = 8'(MAX_WRITES);
    localparam address_t    SEED_EFF = (SEED == 5'd0) ? 5'd1 : SEED;

    typedef enum logic [1:0] { IDLE, RUN, DONE } state_t;

    state_t        state;
    logic [1:0]    mode_q;
    address_t      addr;
    instr_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (fill == DEPTH);
    assign empty    = (fill == '0);
    assign in_ready = !full && !start;
    assign push     = in_valid && in_ready;
    assign pop      = (state == RUN) && !empty
                   && (write_count < MAXW) && !start;

    function automatic address_t first_addr(input logic [1:0] m);
        unique case (m)
            2'd1:    first_addr = 5'd31;
            2'd2:    first_addr = SEED_EFF;
            default: first_addr = 5'd0;
        endcase
    endfunction

    // Galois form of x^5+x^3+1: shift right, fold the dropped bit into taps.
    function automatic address_t next_addr(input address_t a,
                                           input logic [1:0] m);
        address_t lfsr;
        lfsr = {1'b0, a[4:1]} ^ (a[0] ? 5'b10100 : 5'b00000);
        unique case (m)
            2'd1:    next_addr = a - 5'd1;
            2'd2:    next_addr = lfsr;
            default: next_addr = a + 5'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_opcode, in_operand_a, in_operand_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mode_q        <= 2'd0;
            addr          <= 5'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            load_en       <= 1'b0;
            write_pointer <= 5'd0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            written_mask  <= 32'd0;
            write_count   <= 8'd0;
        end else if (start) begin
            // New run: anything still buffered belongs to the old run.
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            mode_q       <= mode;
            addr         <= first_addr(mode);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            load_en      <= 1'b0;
            written_mask <= 32'd0;
            write_count  <= 8'd0;
        end else begin
            load_en <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + AW'(1);
                opcode        <= mem[rd_ptr].op;
                operand_a     <= mem[rd_ptr].a;
                operand_b     <= mem[rd_ptr].b;
                write_pointer <= addr;
                addr          <= next_addr(addr, mode_q);
                written_mask  <= written_mask | (32'd1 << addr);
                write_count   <= write_count + 8'd1;
            end
            fill <= fill + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (state == RUN && write_count == MAXW) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_write_sequencer.sv
// tb_instr_write_sequencer: bench for instr_write_sequencer with a
// MAX_WRITES=20 instance (index 0) and a MAX_WRITES=40 instance (index 1).

module tb_instr_write_sequencer;
    import instr_pkg::*;

    typedef struct {
        int          d;
        logic [1:0]  m;
        int          n;
        logic [4:0]  last;
        logic [31:0] msk;
        logic [7:0]  c;
        logic        dn;
    } vec_t;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic        vld [2];
    opcode_t     opc = '0;
    operand_t    opa = '0;
    operand_t    opb = '0;

    logic        rdy  [2];
    logic        ld   [2];
    logic        busy [2];
    logic        done [2];
    address_t    wp   [2];
    opcode_t     o_op [2];
    operand_t    o_a  [2];
    operand_t    o_b  [2];
    logic [31:0] mask [2];
    logic [7:0]  cnt  [2];

    int checks = 0;
    int errors = 0;

    // reference model: accepted-entry queue, write tally, address expectation
    instr_t      mb [2][64];
    int          mh [2];
    int          mt [2];
    int          mcnt [2];
    logic [31:0] mmask [2];
    logic [31:0] seen [2];
    logic [1:0]  mmode [2];
    bit          mrun [2];
    bit          armed   = 1'b0;
    bit          p_rst   = 1'b0;
    bit          p_start = 1'b0;
    bit          p_push [2];
    logic [1:0]  p_mode  = 2'd0;
    instr_t      p_ent   = '0;

    vec_t tbl [6];

    always #5 clk = ~clk;

    instr_write_sequencer #(.MAX_WRITES(20)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_opcode(opc),
        .in_operand_a(opa), .in_operand_b(opb),
        .load_en(ld[0]), .write_pointer(wp[0]), .opcode(o_op[0]),
        .operand_a(o_a[0]), .operand_b(o_b[0]),
        .written_mask(mask[0]), .write_count(cnt[0]),
        .busy(busy[0]), .done(done[0])
    );

    instr_write_sequencer #(.MAX_WRITES(40)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_opcode(opc),
        .in_operand_a(opa), .in_operand_b(opb),
        .load_en(ld[1]), .write_pointer(wp[1]), .opcode(o_op[1]),
        .operand_a(o_a[1]), .operand_b(o_b[1]),
        .written_mask(mask[1]), .write_count(cnt[1]),
        .busy(busy[1]), .done(done[1])
    );

    function automatic int maxw(input int i);
        return (i == 0) ? 20 : 40;
    endfunction

    function automatic void chk(input string nm, input int i,
                                input logic [31:0] act,
                                input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h @%0t",
                     nm, i, act, want, $time);
        end
    endfunction

    task automatic check_write(input int i);
        instr_t   e;
        address_t ea;
        int       k;
        if (!mrun[i] || mt[i] == mh[i]) begin
            chk("unexpected_load_en", i, 32'(ld[i]), 32'd0);
        end else begin
            e = mb[i][mh[i] % 64];
            mh[i]++;
            k = mcnt[i];
            chk("opcode", i, 32'(o_op[i]), 32'(e.op));
            chk("operand_a", i, o_a[i], e.a);
            chk("operand_b", i, o_b[i], e.b);
            if (mmode[i] == 2'd2) begin
                chk("lfsr_zero_addr", i, 32'(wp[i] == 5'd0), 32'd0);
                if (k % 31 == 0) begin
                    chk("lfsr_seed_addr", i, 32'(wp[i]), 32'h1F);
                    seen[i] = 32'd0;
                end else begin
                    chk("lfsr_repeat", i, 32'(seen[i][wp[i]]), 32'd0);
                end
                seen[i][wp[i]] = 1'b1;
                ea = wp[i];
            end else begin
                ea = (mmode[i] == 2'd1) ? 5'(31 - k % 32) : 5'(k % 32);
                chk("write_pointer", i, 32'(wp[i]), 32'(ea));
            end
            mmask[i][ea] = 1'b1;
            mcnt[i]++;
            if (mcnt[i] == maxw(i)) mrun[i] = 1'b0;
        end
    endtask

    // Outputs seen at negedge reflect the previous posedge; the inputs
    // captured here are the ones that posedge will act on next.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                if (p_rst) begin
                    mh[i] = 0; mt[i] = 0; mcnt[i] = 0;
                    mmask[i] = 32'd0; seen[i] = 32'd0; mrun[i] = 1'b0;
                    chk("rst_load_en", i, 32'(ld[i]), 32'd0);
                    chk("rst_write_pointer", i, 32'(wp[i]), 32'd0);
                    chk("rst_opcode", i, 32'(o_op[i]), 32'd0);
                    chk("rst_operand_a", i, o_a[i], 32'd0);
                    chk("rst_operand_b", i, o_b[i], 32'd0);
                    chk("rst_busy", i, 32'(busy[i]), 32'd0);
                    chk("rst_done", i, 32'(done[i]), 32'd0);
                end else if (p_start) begin
                    mh[i] = mt[i]; mcnt[i] = 0;
                    mmask[i] = 32'd0; seen[i] = 32'd0;
                    mrun[i] = 1'b1; mmode[i] = p_mode;
                    chk("start_load_en", i, 32'(ld[i]), 32'd0);
                end else begin
                    if (ld[i]) check_write(i);
                    if (p_push[i]) begin
                        mb[i][mt[i] % 64] = p_ent;
                        mt[i]++;
                    end
                end
                chk("write_count", i, 32'(cnt[i]), 32'(mcnt[i]));
                chk("written_mask", i, mask[i], mmask[i]);
                chk("in_ready", i, 32'(rdy[i]),
                    32'(((mt[i] - mh[i]) < 4) && !start));
                if (done[i]) chk("done_count", i, 32'(mcnt[i]), 32'(maxw(i)));
            end
        end
        if (!reset_n) armed = 1'b1;
        p_rst   = !reset_n;
        p_start = start;
        p_mode  = mode;
        p_ent   = {opc, opa, opb};
        for (int i = 0; i < 2; i++) p_push[i] = vld[i] && rdy[i];
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rnd_data();
        opc = opcode_t'($urandom);
        opa = operand_t'($urandom);
        opb = operand_t'($urandom);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input int d, input int n);
        int sent = 0;
        int g    = 0;
        bit tk;
        while (sent < n && g < 400) begin
            vld[d] = 1'b1;
            rnd_data();
            @(negedge clk);
            tk = rdy[d];
            @(posedge clk);
            #1;
            if (tk) sent++;
            g++;
        end
        vld[d] = 1'b0;
        if (sent < n) chk("send_timeout", d, 32'(sent), 32'(n));
    endtask

    task automatic drain(input int d);
        int g = 0;
        cyc(1);
        while (mt[d] != mh[d] && g < 300) begin
            cyc(1);
            g++;
        end
        if (g >= 300) chk("drain_timeout", d, 32'(mt[d] - mh[d]), 32'd0);
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        vld[0] = 1'b0;
        vld[1] = 1'b0;

        tbl[0] = '{0, 2'd0, 20, 5'd19, 32'h000F_FFFF, 8'd20, 1'b1};
        tbl[1] = '{0, 2'd1, 20, 5'd12, 32'hFFFF_F000, 8'd20, 1'b1};
        tbl[2] = '{0, 2'd3,  5, 5'd4,  32'h0000_001F, 8'd5,  1'b0};
        tbl[3] = '{1, 2'd2, 31, 5'h17, 32'hFFFF_FFFE, 8'd31, 1'b0};
        tbl[4] = '{1, 2'd1, 10, 5'd22, 32'hFFC0_0000, 8'd10, 1'b0};
        tbl[5] = '{1, 2'd0, 40, 5'd7,  32'hFFFF_FFFF, 8'd40, 1'b1};

        cyc(2);
        reset_n = 1'b1;
        cyc(1);

        // producer stalled in IDLE: only FIFO_DEPTH entries get in
        acc = 0;
        vld[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rnd_data();
            @(negedge clk);
            if (rdy[0]) acc++;
            @(posedge clk);
            #1;
        end
        chk("idle_accepts", 0, 32'(acc), 32'd4);
        @(negedge clk);
        chk("idle_in_ready", 0, 32'(rdy[0]), 32'd0);
        chk("idle_busy", 0, 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        pulse_start(2'd0);
        send(0, 6);
        drain(0);
        chk("idle_then_run_ptr", 0, 32'(wp[0]), 32'd5);
        chk("idle_then_run_cnt", 0, 32'(cnt[0]), 32'd6);

        // single transfer into an empty FIFO: write two cycles later
        vld[0] = 1'b1;
        rnd_data();
        cyc(1);
        vld[0] = 1'b0;
        @(negedge clk);
        chk("latency_cycle1", 0, 32'(ld[0]), 32'd0);
        @(negedge clk);
        chk("latency_cycle2", 0, 32'(ld[0]), 32'd1);
        chk("latency_ptr", 0, 32'(wp[0]), 32'd6);
        @(posedge clk);
        #1;

        // reset in the middle of a run with entries still buffered
        pulse_start(2'd0);
        send(0, 5);
        drain(0);
        send(0, 2);
        reset_n = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("midrst_load_en", 0, 32'(ld[0]), 32'd0);
        chk("midrst_count", 0, 32'(cnt[0]), 32'd0);
        chk("midrst_mask", 0, mask[0], 32'd0);
        chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(2);
        pulse_start(2'd0);
        send(0, 1);
        drain(0);
        chk("restart_ptr", 0, 32'(wp[0]), 32'd0);
        chk("restart_count", 0, 32'(cnt[0]), 32'd1);

        for (int t = 0; t < 6; t++) begin
            pulse_start(tbl[t].m);
            send(tbl[t].d, tbl[t].n);
            drain(tbl[t].d);
            chk("tbl_last_ptr", t, 32'(wp[tbl[t].d]), 32'(tbl[t].last));
            chk("tbl_mask", t, mask[tbl[t].d], tbl[t].msk);
            chk("tbl_count", t, 32'(cnt[tbl[t].d]), 32'(tbl[t].c));
            chk("tbl_done", t, 32'(done[tbl[t].d]), 32'(tbl[t].dn));
            chk("tbl_busy", t, 32'(busy[tbl[t].d]), 32'(!tbl[t].dn));
        end

        // DONE keeps filling the FIFO but never writes
        send(1, 4);
        vld[1] = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("done_in_ready", 1, 32'(rdy[1]), 32'd0);
        chk("done_load_en", 1, 32'(ld[1]), 32'd0);
        chk("done_count_hold", 1, 32'(cnt[1]), 32'd40);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            vld[0]  = ($urandom % 4) != 0;
            vld[1]  = ($urandom % 3) == 0;
            rnd_data();
            mode    = 2'($urandom);
            start   = ($urandom % 50) == 0;
            reset_n = ($urandom % 400) != 0;
            cyc(1);
        end
        vld[0]  = 1'b0;
        vld[1]  = 1'b0;
        start   = 1'b0;
        reset_n = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
